clk_tick_gen: RTL and testbench
===============================

Name: clk_tick_gen

Overview:
- Parametrised cascaded clock-enable generator. It is the next generation of the top-level 1 kHz / 100 Hz / 2 Hz divider chain.
- It produces NUM_CH single-cycle tick enables and matching 50 % square levels, all in the clk_in domain. No derived clocks are produced.
- Adds run/pause, synchronous clear, and glitch-free runtime divisor reprogramming.
- Sits between the IBUFDS clock and the display scan, keyboard debounce and LED blink logic.

Parameters:
- NUM_CH, 3, number of cascaded channels (1..8).
- CNT_W, 24, width of each channel counter and divisor.
- DIV_INIT, {50, 10, 50_000}, packed NUM_CH*CNT_W reset divisors. Channel k occupies bits [k*CNT_W +: CNT_W], so ch0 = 50_000, ch1 = 10, ch2 = 50.
- SEL_W, 2, width of div_sel; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk_in  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-low reset.
- run  in  1  1 = counting enabled; 0 = all counters and outputs hold.
- clr  in  1  synchronous clear, priority over run.
- div_wr  in  1  one-cycle divisor write strobe.
- div_sel  in  SEL_W  target channel of the write.
- div_data  in  CNT_W  new divisor value.
- tick  out  NUM_CH  one-cycle enable pulse per channel.
- sq  out  NUM_CH  square level per channel; toggles on each tick.
- pend  out  NUM_CH  divisor update pending per channel.

Behaviour:
- Reset (rst = 0, asynchronous):
  - cnt[k] = 0; active div[k] = shadow[k] = DIV_INIT slice.
  - tick = 0, sq = 0, pend = 0.
- Event source:
  - ch0 sees an event every clk_in cycle with run = 1.
  - ch k (k > 0) sees an event in each cycle where tick[k-1] = 1 and run = 1.
- Counting, on each event:
  - If cnt[k] == div[k]-1: cnt[k] <= 0, tick[k] <= 1 the next cycle, sq[k] toggles in the same cycle tick[k] is asserted.
  - Otherwise cnt[k] increments.
  - tick[k] is 0 in every cycle without a terminal event.
- Latency:
  - tick[k] is registered, so each cascade stage lags its upstream tick by 1 cycle.
  - Periods: P0 = div0, Pk = P(k-1)*divk.
  - With defaults from 100 MHz: ticks at 2 kHz / 200 Hz / 4 Hz; sq at 1 kHz / 100 Hz / 2 Hz.
- Divisor 0 or 1: treated as 1, so every event is terminal and tick repeats every event.
- run = 0:
  - cnt, sq and div hold; tick forced 0 from the next cycle.
  - A tick[k-1] already high while run falls is not consumed.
  - Resuming continues from the held count.
- clr = 1 (any run value):
  - Next cycle: cnt = 0, tick = 0, sq = 0.
  - Every channel with pend = 1 loads shadow into div and clears pend.
- Divisor write, div_wr = 1 with div_sel < NUM_CH:
  - shadow[sel] <= div_data, pend[sel] <= 1.
  - div_sel >= NUM_CH: write ignored, no state change.
  - A write while pend = 1 overwrites shadow; only the last value is applied.
- Apply:
  - At channel k's next terminal event with pend[k] = 1: div[k] <= shadow[k], pend[k] <= 0.
  - The current period completes with the old divisor, so there is no runt or stretched period.
- Simultaneous events:
  - Write and terminal event on the same channel in the same cycle: the terminal applies the pre-write pending state (if any). The new value lands in shadow with pend = 1 and applies at the following terminal.
  - Write and clr in the same cycle: clr applies the old pending shadow; the new write then remains pending.
- rst asserted mid-operation: immediate return to reset values, including discarding pending writes.

Test Plan (NUM_CH = 3, CNT_W = 8, DIV_INIT ch0 = 4, ch1 = 3, ch2 = 2):
- Free run: release rst, run = 1 → tick[0] first high 4 cycles after run and every 4 thereafter. tick[1] period 12, 1 cycle after every third tick[0]. tick[2] period 24. sq[0] period 8, 50 % duty.
- Pause: run = 0 for 10 cycles when cnt0 = 2 → no ticks, sq frozen. After run = 1, the next tick[0] comes 2 cycles later.
- Reprogram: write ch0 = 6 mid-period → pend[0] = 1. The current period stays 4, then the period is 6 and pend[0] = 0. A second write (ch0 = 2) before the apply → only 2 takes effect.
- Edge divisors: write ch1 = 0, then ch1 = 1 → tick[1] follows every tick[0] with 1-cycle lag. Write with div_sel = 3 → no pend bit set, periods unchanged.
- Clear: clr pulse with pend[2] = 1 and sq = 1 → next cycle all cnt = 0, sq = 0, pend = 0, div2 = new value. Write + clr in the same cycle → pend stays 1 for the new value.
- Async reset: drop rst mid-count with pend set → outputs 0 immediately without a clock edge. After release, periods are back to 4 / 12 / 24.

Source files
------------

// File: rtl/clk_tick_gen.sv
// -----------------------------------------------------------------------------
// clk_tick_gen
//
// Cascaded clock-enable generator. Produces NUM_CH single-cycle tick enables
// and matching 50 % square levels, all synchronous to clk_in. No derived clocks
// are produced. Channel 0 counts clk_in cycles; channel k counts ticks of
// channel k-1. Each channel divides by its own divisor, which can be changed at
// runtime without runt or stretched periods.
//
// Parameters:
//   NUM_CH   number of cascaded channels (1..8)
//   CNT_W    width of each channel counter and divisor
//   DIV_INIT packed reset divisors, channel k in bits [k*CNT_W +: CNT_W]
//   SEL_W    width of div_sel, 2**SEL_W >= NUM_CH
//
// Ports:
//   clk_in    system clock
//   rst       asynchronous, active-low reset
//   run       1 = counting enabled, 0 = counters/levels hold, ticks drop
//   clr       synchronous clear of counters/ticks/levels, overrides run;
//             also applies any pending divisor
//   div_wr    one-cycle divisor write strobe
//   div_sel   channel targeted by the write (values >= NUM_CH are ignored)
//   div_data  new divisor value (0 and 1 both mean "every event")
//   tick      one-cycle enable pulse per channel
//   sq        square level per channel, toggles with each tick
//   pend      divisor update pending per channel
// -----------------------------------------------------------------------------
module clk_tick_gen #(
  parameter int                        NUM_CH   = 3,
  parameter int                        CNT_W    = 24,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {24'd50, 24'd10, 24'd50_000},
  parameter int                        SEL_W    = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              run,
  input  logic              clr,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pend
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] shadow_reg;
    logic             tick_reg;
    logic             sq_reg;
    logic             pend_reg;

    logic             ev;
    logic             term;
    logic             wr_hit;
    logic [CNT_W-1:0] last_cnt;

    // Channel 0 advances on every running cycle; later stages advance on the
    // upstream tick. A tick already high when run falls is simply dropped.
    if (gi == 0) begin : g_src_clk
      assign ev = run;
    end else begin : g_src_tick
      assign ev = run & g_ch[gi-1].tick_reg;
    end

    // Divisors 0 and 1 both collapse to "terminal on every event".
    assign last_cnt = (div_reg > CNT_W'(1)) ? (div_reg - CNT_W'(1)) : '0;
    assign term     = ev && (cnt_reg == last_cnt);

    // Only channel indices below NUM_CH can ever match, so out-of-range
    // selects fall through without touching any state.
    assign wr_hit   = div_wr && (div_sel == SEL_W'(gi));

    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        cnt_reg    <= '0;
        div_reg    <= DIV_INIT[gi*CNT_W +: CNT_W];
        shadow_reg <= DIV_INIT[gi*CNT_W +: CNT_W];
        tick_reg   <= 1'b0;
        sq_reg     <= 1'b0;
        pend_reg   <= 1'b0;
      end else begin
        if (clr) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
          sq_reg   <= 1'b0;
          if (pend_reg) begin
            div_reg  <= shadow_reg;
            pend_reg <= 1'b0;
          end
        end else begin
          tick_reg <= term;
          if (term) begin
            cnt_reg <= '0;
            sq_reg  <= ~sq_reg;
            // New divisor takes over only at a period boundary, and the
            // counter restarts from 0, so it can never exceed the new limit.
            if (pend_reg) begin
              div_reg  <= shadow_reg;
              pend_reg <= 1'b0;
            end
          end else if (ev) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        // A write lands after any apply in the same cycle: the apply above
        // used the old shadow, and the fresh value stays pending.
        if (wr_hit) begin
          shadow_reg <= div_data;
          pend_reg   <= 1'b1;
        end
      end
    end

    assign tick[gi] = tick_reg;
    assign sq[gi]   = sq_reg;
    assign pend[gi] = pend_reg;
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_tick_gen
//
// Directed bench for clk_tick_gen with NUM_CH = 3, CNT_W = 8 and reset
// divisors ch0 = 4, ch1 = 3, ch2 = 2. Cycle index c counts rising edges after
// counting (re)starts; expected ticks/levels are hand-derived from the
// divider periods.
// -----------------------------------------------------------------------------
module tb_clk_tick_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 2;

  logic              clk_in   = 1'b0;
  logic              rst      = 1'b1;
  logic              run      = 1'b0;
  logic              clr      = 1'b0;
  logic              div_wr   = 1'b0;
  logic [SEL_W-1:0]  div_sel  = '0;
  logic [CNT_W-1:0]  div_data = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] pend;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  clk_tick_gen #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT ({8'd2, 8'd3, 8'd4}),
    .SEL_W    (SEL_W)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .run      (run),
    .clr      (clr),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_data (div_data),
    .tick     (tick),
    .sq       (sq),
    .pend     (pend)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Clear with run low, then start counting; c = 1 is the next edge.
  task automatic restart(input string tag);
    run = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk({tag, "_clr_tick"}, tick, 3'b000);
    chk({tag, "_clr_sq"},   sq,   3'b000);
    chk({tag, "_clr_pend"}, pend, 3'b000);
    run = 1'b1;
  endtask

  task automatic wr_one(input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] data);
    div_wr   = 1'b1;
    div_sel  = sel;
    div_data = data;
    step();
    div_wr   = 1'b0;
  endtask

  // Default divisors 4/3/2: ticks at c%4==0, c%12==1, c%24==2.
  task automatic free_run(input string tag);
    logic [2:0] exp_t;
    logic [2:0] exp_s;
    for (int c = 1; c <= 48; c++) begin
      step();
      exp_t[0] = (c % 4 == 0);
      exp_t[1] = (c % 12 == 1) && (c > 1);
      exp_t[2] = (c % 24 == 2) && (c > 2);
      exp_s[0] = ((c / 4) % 2) == 1;
      exp_s[1] = (((c - 1) / 12) % 2) == 1;
      exp_s[2] = (c >= 2) ? ((((c - 2) / 24) % 2) == 1) : 1'b0;
      chk($sformatf("%s_tick_c%0d", tag, c), tick, exp_t);
      chk($sformatf("%s_sq_c%0d", tag, c), sq, exp_s);
    end
    $display("phase %s: 48 cycles checked", tag);
  endtask

  // Divisors 4/1/2: ch1 follows ch0 by one cycle, ch2 every second ch1 tick.
  task automatic edge_run(input string tag);
    logic [2:0] exp_t;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_t[0] = (c % 4 == 0);
      exp_t[1] = (c % 4 == 1) && (c > 1);
      exp_t[2] = (c % 8 == 2) && (c > 2);
      chk($sformatf("%s_tick_c%0d", tag, c), tick, exp_t);
    end
    $display("phase %s: 20 cycles checked", tag);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) step();
    chk("reset_tick", tick, 3'b000);
    chk("reset_sq",   sq,   3'b000);
    chk("reset_pend", pend, 3'b000);

    // Free run from reset release.
    rst = 1'b1;
    run = 1'b1;
    free_run("free");

    // Pause at cnt0 = 2 with sq0 = 1, then resume; then drop run while
    // tick0 is high and confirm ch1 did not consume it.
    restart("pause");
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("pause_pre_t0_c%0d", c), tick[0], (c == 4));
    end
    run = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("pause_tick_%0d", i), tick, 3'b000);
      chk($sformatf("pause_sq_%0d", i),   sq,   3'b001);
    end
    run = 1'b1;
    step();
    chk("resume_t_1", tick, 3'b000);
    step();
    chk("resume_t_2", tick, 3'b001);
    run = 1'b0;
    step();
    chk("drop_tick", tick, 3'b000);
    run = 1'b1;
    for (int s = 1; s <= 9; s++) begin
      step();
      chk($sformatf("noconsume_tick_s%0d", s), tick,
          {1'b0, (s == 9), (s % 4 == 0)});
    end
    $display("phase pause: done");

    // Reprogram ch0 mid-period (6), then double write (5 then 2).
    restart("reprog");
    for (int c = 1; c <= 20; c++) begin
      if (c == 2)  begin div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd6; end
      if (c == 11) begin div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd5; end
      if (c == 12) begin div_wr = 1'b1; div_sel = 2'd0; div_data = 8'd2; end
      step();
      div_wr = 1'b0;
      chk($sformatf("reprog_t0_c%0d", c), tick[0],
          (c == 4) || (c == 10) || (c == 16) || (c == 18) || (c == 20));
      chk($sformatf("reprog_pend_c%0d", c), pend,
          ((c >= 2 && c <= 3) || (c >= 11 && c <= 15)) ? 3'b001 : 3'b000);
    end
    $display("phase reprog: done");

    // Edge divisors: ch0 back to 4, ch1 = 0 then ch1 = 1, plus an
    // out-of-range select that must not set any pend bit.
    run = 1'b0;
    wr_one(2'd0, 8'd4);
    wr_one(2'd1, 8'd0);
    chk("edge0_pend", pend, 3'b011);
    restart("edge0");
    edge_run("edge0");
    run = 1'b0;
    wr_one(2'd1, 8'd1);
    wr_one(2'd3, 8'd9);
    chk("sel3_pend", pend, 3'b010);
    restart("edge1");
    edge_run("edge1");

    // Clear with pend[2] set and sq nonzero, then write + clr together.
    restart("clear");
    for (int c = 1; c <= 4; c++) step();
    chk("clear_pre_sq", sq, 3'b001);
    wr_one(2'd2, 8'd3);
    chk("clear_pre_pend", pend, 3'b100);
    chk("clear_pre_sq2",  sq,   3'b011);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clear_tick", tick, 3'b000);
    chk("clear_sq",   sq,   3'b000);
    chk("clear_pend", pend, 3'b000);
    clr      = 1'b1;
    div_wr   = 1'b1;
    div_sel  = 2'd2;
    div_data = 8'd5;
    step();
    clr    = 1'b0;
    div_wr = 1'b0;
    chk("wrclr_pend", pend, 3'b100);
    for (int c = 1; c <= 34; c++) begin
      step();
      chk($sformatf("clear_tick_c%0d", c), tick,
          {((c == 14) || (c == 34)), ((c % 4 == 1) && (c > 1)), (c % 4 == 0)});
      if (c == 13) chk("apply3_pend_before", pend, 3'b100);
      if (c == 14) chk("apply3_pend_after",  pend, 3'b000);
    end
    $display("phase clear: done");

    // Write on the same edge as a ch0 terminal, then async reset mid-count.
    step();                      // c = 35
    wr_one(2'd0, 8'd9);          // c = 36, ch0 terminal
    chk("wrterm_pend", pend, 3'b001);
    chk("wrterm_tick", tick, 3'b001);
    chk("wrterm_sq",   sq,   3'b001);
    rst = 1'b0;
    #1;
    chk("async_tick", tick, 3'b000);
    chk("async_sq",   sq,   3'b000);
    chk("async_pend", pend, 3'b000);
    #2 rst = 1'b1;
    free_run("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
